// File: rtl/ul_coeff_loader.sv
// Write-side sequencer for the FIR coefficient memory: streams one coefficient set into
// consecutive memory indices, then raises the update strobe so the filter switches atomically.
module ul_coeff_loader #(
  parameter int COEFF_WIDTH      = 16,
  parameter int NOF_COEFFS       = 32,
  parameter int UPDATE_PULSE_LEN = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [COEFF_WIDTH-1:0] s_coeff_data_i,
  input  logic                   s_coeff_valid_i,
  output logic                   s_coeff_ready_o,
  output logic [COEFF_WIDTH-1:0] coeff_o,
  output logic [6:0]             coeff_index_o,
  output logic                   coeff_wren_o,
  output logic                   coeff_update_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  // state  | meaning
  // IDLE   | waiting for start_i; stream not ready
  // LOAD   | accepting beats, one memory write per accepted beat
  // COMMIT | update strobe for UPDATE_PULSE_LEN cycles, then done_o

  if (NOF_COEFFS < 1 || NOF_COEFFS > 64) begin : g_bad_nof
    $error("ul_coeff_loader: NOF_COEFFS must be 1..64");
  end
  if (UPDATE_PULSE_LEN < 1) begin : g_bad_pulse
    $error("ul_coeff_loader: UPDATE_PULSE_LEN must be >= 1");
  end

  localparam int PW = (UPDATE_PULSE_LEN < 2) ? 1 : $clog2(UPDATE_PULSE_LEN + 1);
  localparam logic [6:0]    LAST_IDX  = 7'(NOF_COEFFS - 1);
  localparam logic [PW-1:0] PULSE_LEN = PW'(UPDATE_PULSE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [6:0]             beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]          pulse_cnt_q, pulse_cnt_d;
  logic [COEFF_WIDTH-1:0] coeff_q, coeff_d;
  logic [6:0]             index_q, index_d;
  logic                   wren_q, wren_d;
  logic                   update_q, update_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   ready;
  logic                   accept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      coeff_q     <= '0;
      index_q     <= '0;
      wren_q      <= 1'b0;
      update_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      coeff_q     <= coeff_d;
      index_q     <= index_d;
      wren_q      <= wren_d;
      update_q    <= update_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    coeff_d     = coeff_q;
    index_d     = index_q;
    wren_d      = 1'b0;
    update_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = S_LOAD;
          beat_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
          error_d    = 1'b1;
        end else if (accept) begin
          coeff_d = s_coeff_data_i;
          index_d = beat_cnt_q;
          wren_d  = 1'b1;
          // Counter parks on the last index instead of wrapping.
          if (beat_cnt_q == LAST_IDX) begin
            state_d     = S_COMMIT;
            pulse_cnt_d = PULSE_LEN;
          end else begin
            beat_cnt_d = beat_cnt_q + 7'd1;
          end
        end
      end
      S_COMMIT: begin
        if (pulse_cnt_q != '0) begin
          update_d    = 1'b1;
          pulse_cnt_d = pulse_cnt_q - PW'(1);
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == S_LOAD) && !abort_i;
    accept = ready && s_coeff_valid_i;
  end

  assign s_coeff_ready_o = ready;
  assign busy_o          = (state_q != S_IDLE);
  assign coeff_o         = coeff_q;
  assign coeff_index_o   = index_q;
  assign coeff_wren_o    = wren_q;
  assign coeff_update_o  = update_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_ul_coeff_loader.sv
// Directed bench for ul_coeff_loader: a 4-coefficient instance for sequencing details and a
// 32-coefficient instance driving a behavioural coefficient memory.
module tb_ul_coeff_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic        start4, abort4, valid4, ready4, wren4, update4, busy4, done4, error4;
  logic [15:0] data4, coeff4;
  logic [6:0]  index4;

  logic        start32, abort32, valid32, ready32, wren32, update32, busy32, done32, error32;
  logic [15:0] data32, coeff32;
  logic [6:0]  index32;

  ul_coeff_loader #(.COEFF_WIDTH(16), .NOF_COEFFS(4), .UPDATE_PULSE_LEN(2)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .abort_i(abort4),
    .s_coeff_data_i(data4), .s_coeff_valid_i(valid4), .s_coeff_ready_o(ready4),
    .coeff_o(coeff4), .coeff_index_o(index4), .coeff_wren_o(wren4),
    .coeff_update_o(update4), .busy_o(busy4), .done_o(done4), .error_o(error4));

  ul_coeff_loader #(.COEFF_WIDTH(16), .NOF_COEFFS(32), .UPDATE_PULSE_LEN(2)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start32), .abort_i(abort32),
    .s_coeff_data_i(data32), .s_coeff_valid_i(valid32), .s_coeff_ready_o(ready32),
    .coeff_o(coeff32), .coeff_index_o(index32), .coeff_wren_o(wren32),
    .coeff_update_o(update32), .busy_o(busy32), .done_o(done32), .error_o(error32));

  // Coefficient memory model: write port plus active set latched on update rising edge.
  logic [15:0] mem [0:127];
  logic [15:0] act [0:31];
  logic        upd_prev;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'h0000;
      for (int i = 0; i < 32; i++) act[i] <= (i == 16) ? 16'h4000 : 16'h0000;
      upd_prev <= 1'b0;
    end else begin
      if (wren32) mem[index32] <= coeff32;
      upd_prev <= update32;
      if (update32 && !upd_prev)
        for (int i = 0; i < 32; i++) act[i] <= mem[i];
    end
  end

  task automatic test_reset();
    tests++;
    if ({busy4, ready4, wren4, update4, done4, error4} !== 6'b0) begin
      failed++; $display("FAIL reset_ctrl4: got %b exp 000000", {busy4, ready4, wren4, update4, done4, error4});
    end
    tests++;
    if ({index4, coeff4} !== 23'h0) begin
      failed++; $display("FAIL reset_data4: got %h/%h exp 0/0", index4, coeff4);
    end
    tests++;
    if ({busy32, ready32, wren32, update32, done32, error32} !== 6'b0) begin
      failed++; $display("FAIL reset_ctrl32: got %b exp 000000", {busy32, ready32, wren32, update32, done32, error32});
    end
  endtask

  // Full 4-beat load; gap inserts idle beats, noise holds start in LOAD and start/abort in COMMIT.
  task automatic test_load(input bit gap, input bit noise);
    int beat, cyc;
    bit acc;
    logic [15:0] d;
    start4 = 1'b1;
    @(negedge clk);
    start4 = noise;
    tests++;
    if (busy4 !== 1'b1 || error4 !== 1'b0) begin
      failed++; $display("FAIL load_start: busy %b err %b exp 1 0", busy4, error4);
    end
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 40) begin
      valid4 = gap ? (cyc % 2 == 0) : 1'b1;
      d = 16'h0101 + 16'(beat);
      data4 = d;
      #1;
      tests++;
      if (ready4 !== 1'b1) begin
        failed++; $display("FAIL load_ready: got %b exp 1 beat %0d", ready4, beat);
      end
      acc = valid4;
      @(negedge clk);
      tests++;
      if (wren4 !== acc) begin
        failed++; $display("FAIL load_wren: got %b exp %b cyc %0d", wren4, acc, cyc);
      end
      if (acc) begin
        tests++;
        if (index4 !== 7'(beat) || coeff4 !== d) begin
          failed++; $display("FAIL load_write: got idx %0d data %h exp %0d %h", index4, coeff4, beat, d);
        end
        beat++;
      end
      cyc++;
    end
    valid4 = 1'b0;
    tests++;
    if (beat != 4) begin
      failed++; $display("FAIL load_timeout: got %0d beats exp 4", beat);
    end
    tests++;
    if (ready4 !== 1'b0 || update4 !== 1'b0) begin
      failed++; $display("FAIL commit_entry: ready %b upd %b exp 0 0", ready4, update4);
    end
    for (int k = 0; k < 4; k++) begin
      start4 = noise && (k < 3);
      abort4 = noise && (k < 3);
      @(negedge clk);
      tests++;
      if (update4 !== (k < 2) || done4 !== (k == 2) || busy4 !== (k < 2)) begin
        failed++; $display("FAIL commit_seq k%0d: upd %b done %b busy %b exp %b %b %b",
                           k, update4, done4, busy4, k < 2, k == 2, k < 2);
      end
    end
    start4 = 1'b0;
    abort4 = 1'b0;
  endtask

  task automatic test_abort();
    bit upd_seen;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    valid4 = 1'b1; data4 = 16'h0A01;
    @(negedge clk);
    data4 = 16'h0A02;
    @(negedge clk);
    tests++;
    if (wren4 !== 1'b1 || index4 !== 7'd1) begin
      failed++; $display("FAIL abort_pre: wren %b idx %0d exp 1 1", wren4, index4);
    end
    abort4 = 1'b1; data4 = 16'h0A03;
    #1;
    tests++;
    if (ready4 !== 1'b0) begin
      failed++; $display("FAIL abort_ready: got %b exp 0", ready4);
    end
    @(negedge clk);
    abort4 = 1'b0; valid4 = 1'b0;
    tests++;
    if (wren4 !== 1'b0 || busy4 !== 1'b0 || error4 !== 1'b1 || index4 !== 7'd1) begin
      failed++; $display("FAIL abort_post: wren %b busy %b err %b idx %0d exp 0 0 1 1",
                         wren4, busy4, error4, index4);
    end
    upd_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      upd_seen |= update4 | done4;
    end
    tests++;
    if (upd_seen !== 1'b0) begin
      failed++; $display("FAIL abort_noupdate: got %b exp 0", upd_seen);
    end
  endtask

  task automatic test_start_abort_idle();
    start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    tests++;
    if (busy4 !== 1'b0 || error4 !== 1'b1) begin
      failed++; $display("FAIL start_abort_idle: busy %b err %b exp 0 1", busy4, error4);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    tests++;
    if (busy4 !== 1'b1 || error4 !== 1'b0) begin
      failed++; $display("FAIL start_clears_err: busy %b err %b exp 1 0", busy4, error4);
    end
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
  endtask

  task automatic test_async_reset();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    valid4 = 1'b1; data4 = 16'h0B01;
    @(negedge clk);
    data4 = 16'h0B02;
    @(negedge clk);
    valid4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy4, ready4, wren4, update4, done4, error4} !== 6'b0 || {index4, coeff4} !== 23'h0) begin
      failed++; $display("FAIL async_reset: ctrl %b idx %0d data %h exp 0", {busy4, ready4, wren4, update4, done4, error4}, index4, coeff4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_integration();
    logic [15:0] exp_set [0:31];
    int b, cyc, bad;
    bit acc;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    valid32 = 1'b1; data32 = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    abort32 = 1'b1;
    @(negedge clk);
    abort32 = 1'b0; valid32 = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (act[16] !== 16'h4000 || act[0] !== 16'h0000 || error32 !== 1'b1) begin
      failed++; $display("FAIL int_abort: tap16 %h tap0 %h err %b exp 4000 0000 1", act[16], act[0], error32);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) exp_set[i] = 16'($urandom);
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      b = 0; cyc = 0;
      while (b < 32 && cyc < 200) begin
        valid32 = 1'b1; data32 = exp_set[b];
        #1 acc = ready32;
        @(negedge clk);
        if (acc) b++;
        cyc++;
      end
      valid32 = 1'b0;
      tests++;
      if (cyc != 32) begin
        failed++; $display("FAIL int_throughput r%0d: got %0d cycles exp 32", r, cyc);
      end
      cyc = 0;
      while (done32 !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      tests++;
      if (done32 !== 1'b1 || cyc != 3) begin
        failed++; $display("FAIL int_done r%0d: done %b after %0d cycles exp 1 after 3", r, done32, cyc);
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 32; i++) if (act[i] !== exp_set[i]) bad++;
      tests++;
      if (bad != 0 || busy32 !== 1'b0) begin
        failed++; $display("FAIL int_set r%0d: %0d taps differ busy %b exp 0 0", r, bad, busy32);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {start4, abort4, valid4, start32, abort32, valid32} = '0;
    data4 = '0; data32 = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_load(1'b0, 1'b0);
    test_load(1'b1, 1'b0);
    test_abort();
    test_start_abort_idle();
    test_load(1'b0, 1'b1);
    test_async_reset();
    test_load(1'b0, 1'b0);
    test_integration();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
